counter_timer_arbiter: RTL

Shares one modulo up-counter timer between NREQ requesters. Each requester asks for a delay of D clock cycles. A round-robin arbiter grants the counter to one requester at a time, runs the count, and pulses `done` back to the owner. The block sits between control FSMs that need timed waits and the counter datapath, replacing one private counter per client.

---
 rtl/counter_timer_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/counter_timer_arbiter.sv
// counter_timer_arbiter: one shared modulo up-counter, lent round-robin to
// NREQ requesters. The owner holds the counter for D counting cycles, then
// gets a one-cycle done pulse. Dropping req early aborts without a pulse.
`timescale 1ns/1ps

module counter_timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*NBITS-1:0] delay,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [NBITS-1:0]      counter
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } state_e;

    state_e            state_q,   state_d;
    logic [NREQ-1:0]   grant_q,   grant_d;
    logic [NBITS-1:0]  delay_q,   delay_d;
    logic [NBITS-1:0]  counter_q, counter_d;
    logic [IDXW-1:0]   last_q,    last_d;

    logic [NBITS-1:0]  delay_arr [NREQ];
    logic              win_valid;
    logic [IDXW-1:0]   win_idx;
    logic [IDXW-1:0]   cand_idx;

    // Unpack the flat delay bus into one field per requester.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign delay_arr[g] = delay[g*NBITS +: NBITS];
    end

    // Round-robin search: first asserted req starting just after last_q.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand_idx = IDXW'((int'(last_q) + off) % NREQ);
            if (req[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and next-register logic for the IDLE/COUNT/DONE sequence.
    always_comb begin
        // NOTE: every target gets a hold-value default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d   = state_q;
        grant_d   = grant_q;
        delay_d   = delay_q;
        counter_d = counter_q;
        last_d    = last_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    delay_d          = delay_arr[win_idx];
                    counter_d        = '0;
                    last_d           = win_idx;
                    state_d          = (delay_arr[win_idx] != '0) ? S_COUNT : S_DONE;
                end
            end
            S_COUNT: begin
                if ((req & grant_q) == '0) begin
                    // Owner withdrew: release without a done pulse; last_q
                    // keeps the aborted index so round-robin moves on.
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    counter_d = '0;
                end else if (counter_q == delay_q - NBITS'(1)) begin
                    // Terminal value reached; counter holds through DONE.
                    state_d = S_DONE;
                end else begin
                    counter_d = counter_q + NBITS'(1);
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                grant_d   = '0;
                counter_d = '0;
            end
            default: begin
                state_d   = S_IDLE;
                grant_d   = '0;
                counter_d = '0;
            end
        endcase
    end

    // State registers; asynchronous clear, last_q parks on NREQ-1 so
    // requester 0 has first priority after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            delay_q   <= '0;
            counter_q <= '0;
            last_q    <= IDXW'(NREQ - 1);
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values regardless of statement order.
            state_q   <= state_d;
            grant_q   <= grant_d;
            delay_q   <= delay_d;
            counter_q <= counter_d;
            last_q    <= last_d;
        end
    end

    // Outputs decode registered state only; done has no path from req.
    always_comb begin
        grant   = grant_q;
        done    = (state_q == S_DONE) ? grant_q : '0;
        busy    = (state_q != S_IDLE);
        counter = counter_q;
    end

endmodule
